// File: rtl/router_pkt_framer_pkg.sv
// Shared types, widths and framing helpers for the router packet framer.
package router_pkg;

    localparam int ADDR_W = 2;
    localparam int LEN_W  = 6;
    localparam int DATA_W = 8;

    localparam logic [ADDR_W-1:0] ADDR_INVALID = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_HEADER  = 3'd1,
        ST_PAYLOAD = 3'd2,
        ST_PARITY  = 3'd3,
        ST_GAP     = 3'd4
    } state_t;

    function automatic logic [DATA_W-1:0] pack_header(
        input logic [LEN_W-1:0]  len,
        input logic [ADDR_W-1:0] addr
    );
        return {len, addr};
    endfunction

    // Even parity over the packet is a running XOR of every framed byte.
    function automatic logic [DATA_W-1:0] parity_fold(
        input logic [DATA_W-1:0] acc,
        input logic [DATA_W-1:0] data
    );
        return acc ^ data;
    endfunction

endpackage

// File: rtl/router_pkt_framer_if.sv
// Command, payload and router-bus handshake bundle for the packet framer.
interface router_pkt_framer_if;
    import router_pkg::*;

    logic                cmd_valid;
    logic                cmd_ready;
    logic [ADDR_W-1:0]   cmd_addr;
    logic [LEN_W-1:0]    cmd_len;
    logic                cmd_bad_parity;
    logic                pl_valid;
    logic                pl_ready;
    logic [DATA_W-1:0]   pl_data;
    logic                busy;
    logic                pkt_valid;
    logic [DATA_W-1:0]   data_out;

    modport slave (
        input  cmd_valid, cmd_addr, cmd_len, cmd_bad_parity,
        input  pl_valid, pl_data, busy,
        output cmd_ready, pl_ready, pkt_valid, data_out
    );

    modport master (
        output cmd_valid, cmd_addr, cmd_len, cmd_bad_parity,
        output pl_valid, pl_data, busy,
        input  cmd_ready, pl_ready, pkt_valid, data_out
    );

endinterface

// File: rtl/router_pkt_framer_fifo.sv
// Flop-based synchronous payload FIFO with occupancy count; head is read combinationally.
module framer_fifo #(
    parameter  int DEPTH = 64,
    parameter  int WIDTH = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic [AW:0]      count
);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW:0]      wr_ptr_r;
    logic [AW:0]      rd_ptr_r;
    logic [AW:0]      count_r;

    // Storage array, written at the tail pointer.
    always_ff @(posedge clock) begin
        if (push) begin
            mem_r[wr_ptr_r[AW-1:0]] <= wdata;
        end
    end

    // Pointers and occupancy; simultaneous push and pop leave count unchanged.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push) begin
                wr_ptr_r <= wr_ptr_r + (AW+1)'(1);
            end
            if (pop) begin
                rd_ptr_r <= rd_ptr_r + (AW+1)'(1);
            end
            case ({push, pop})
                2'b10:   count_r <= count_r + (AW+1)'(1);
                2'b01:   count_r <= count_r - (AW+1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    assign rdata = mem_r[rd_ptr_r[AW-1:0]];
    assign full  = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    assign count = count_r;

endmodule

// File: rtl/router_pkt_framer.sv
// Buffers payload, then frames header/payload/parity onto the router bus under busy back-pressure.
module router_pkt_framer import router_pkg::*; #(
    parameter int GAP_CYCLES = 2,
    parameter int FIFO_DEPTH = 64
) (
    input  logic                 clock,
    input  logic                 resetn,
    router_pkt_framer_if.slave   bus,
    output logic                 cmd_err,
    output logic [15:0]          pkt_count,
    output logic [6:0]           fifo_count
);

    localparam int         FAW      = $clog2(FIFO_DEPTH);
    localparam logic [3:0] GAP_LOAD = 4'(GAP_CYCLES - 1);

    logic [FAW:0]        fifo_cnt_s;
    logic                fifo_full_s;
    logic [DATA_W-1:0]   fifo_rdata_s;
    logic                push_s;
    logic                pop_s;
    logic                illegal_s;
    logic                cmd_ready_s;
    logic                accept_s;

    state_t              state_r,     state_nxt_s;
    logic                pkt_valid_r, pkt_valid_nxt_s;
    logic [DATA_W-1:0]   data_r,      data_nxt_s;
    logic [DATA_W-1:0]   parity_r,    parity_nxt_s;
    logic [LEN_W-1:0]    rem_r,       rem_nxt_s;
    logic                bad_r,       bad_nxt_s;
    logic [3:0]          gap_r,       gap_nxt_s;
    logic [15:0]         pkt_cnt_r,   pkt_cnt_nxt_s;
    logic                cmd_err_r,   cmd_err_nxt_s;

    framer_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_W)
    ) u_fifo (
        .clock  (clock),
        .resetn (resetn),
        .push   (push_s),
        .pop    (pop_s),
        .wdata  (bus.pl_data),
        .rdata  (fifo_rdata_s),
        .full   (fifo_full_s),
        .count  (fifo_cnt_s)
    );

    // Commands are only taken once their whole payload is buffered, so the packet never stalls internally.
    always_comb begin
        illegal_s   = (bus.cmd_addr == ADDR_INVALID) || (bus.cmd_len == {LEN_W{1'b0}});
        cmd_ready_s = (state_r == ST_IDLE) && (illegal_s || (fifo_cnt_s >= (FAW+1)'(bus.cmd_len)));
        accept_s    = bus.cmd_valid && cmd_ready_s;
        push_s      = bus.pl_valid && !fifo_full_s;
    end

    // Next-state and next-bus logic; each transfer preloads the byte shown in the following cycle.
    always_comb begin
        state_nxt_s     = state_r;
        pkt_valid_nxt_s = pkt_valid_r;
        data_nxt_s      = data_r;
        parity_nxt_s    = parity_r;
        rem_nxt_s       = rem_r;
        bad_nxt_s       = bad_r;
        gap_nxt_s       = gap_r;
        pkt_cnt_nxt_s   = pkt_cnt_r;
        cmd_err_nxt_s   = 1'b0;
        pop_s           = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (accept_s && illegal_s) begin
                    cmd_err_nxt_s = 1'b1;
                end else if (accept_s) begin
                    state_nxt_s     = ST_HEADER;
                    pkt_valid_nxt_s = 1'b1;
                    data_nxt_s      = pack_header(bus.cmd_len, bus.cmd_addr);
                    parity_nxt_s    = pack_header(bus.cmd_len, bus.cmd_addr);
                    rem_nxt_s       = bus.cmd_len;
                    bad_nxt_s       = bus.cmd_bad_parity;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_HEADER: begin
                if (!bus.busy) begin
                    state_nxt_s  = ST_PAYLOAD;
                    data_nxt_s   = fifo_rdata_s;
                    parity_nxt_s = parity_fold(parity_r, fifo_rdata_s);
                    pop_s        = 1'b1;
                end else begin
                    state_nxt_s = ST_HEADER;
                end
            end
            ST_PAYLOAD: begin
                if (!bus.busy) begin
                    if (rem_r == LEN_W'(1)) begin
                        state_nxt_s     = ST_PARITY;
                        pkt_valid_nxt_s = 1'b0;
                        data_nxt_s      = parity_r ^ {DATA_W{bad_r}};
                    end else begin
                        rem_nxt_s    = rem_r - LEN_W'(1);
                        data_nxt_s   = fifo_rdata_s;
                        parity_nxt_s = parity_fold(parity_r, fifo_rdata_s);
                        pop_s        = 1'b1;
                    end
                end else begin
                    state_nxt_s = ST_PAYLOAD;
                end
            end
            ST_PARITY: begin
                if (!bus.busy) begin
                    state_nxt_s   = ST_GAP;
                    data_nxt_s    = {DATA_W{1'b0}};
                    pkt_cnt_nxt_s = pkt_cnt_r + 16'd1;
                    gap_nxt_s     = GAP_LOAD;
                end else begin
                    state_nxt_s = ST_PARITY;
                end
            end
            ST_GAP: begin
                if (gap_r == 4'd0) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    gap_nxt_s = gap_r - 4'd1;
                end
            end
            default: begin
                state_nxt_s     = ST_IDLE;
                pkt_valid_nxt_s = 1'b0;
                data_nxt_s      = {DATA_W{1'b0}};
            end
        endcase
    end

    // State and registered outputs; reset aborts any packet in flight.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_r     <= ST_IDLE;
            pkt_valid_r <= 1'b0;
            data_r      <= {DATA_W{1'b0}};
            parity_r    <= {DATA_W{1'b0}};
            rem_r       <= {LEN_W{1'b0}};
            bad_r       <= 1'b0;
            gap_r       <= 4'd0;
            pkt_cnt_r   <= 16'd0;
            cmd_err_r   <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            pkt_valid_r <= pkt_valid_nxt_s;
            data_r      <= data_nxt_s;
            parity_r    <= parity_nxt_s;
            rem_r       <= rem_nxt_s;
            bad_r       <= bad_nxt_s;
            gap_r       <= gap_nxt_s;
            pkt_cnt_r   <= pkt_cnt_nxt_s;
            cmd_err_r   <= cmd_err_nxt_s;
        end
    end

    assign bus.cmd_ready = cmd_ready_s;
    assign bus.pl_ready  = !fifo_full_s;
    assign bus.pkt_valid = pkt_valid_r;
    assign bus.data_out  = data_r;
    assign cmd_err       = cmd_err_r;
    assign pkt_count     = pkt_cnt_r;
    assign fifo_count    = 7'(fifo_cnt_s);

endmodule

// File: tb/tb_router_pkt_framer.sv
// Bench for router_pkt_framer: command table, corner-case sequences and randomized packets vs a byte-stream model.
module tb_router_pkt_framer;
    import router_pkg::*;

    localparam int GAP = 2;

    typedef struct {
        logic [1:0] addr;
        logic [5:0] len;
        logic       bad;
        logic [7:0] first;
        logic       exp_err;
        logic [7:0] exp_hdr;
    } vec_t;

    logic        clock  = 1'b0;
    logic        resetn = 1'b0;
    logic        cmd_err;
    logic [15:0] pkt_count;
    logic [6:0]  fifo_count;

    int total = 0;
    int bad = 0;
    int exp_pkts = 0;
    int rx_pkts = 0;
    int pv_run = 0;
    int last_pv_run = 0;
    logic [7:0] model_q[$];
    logic [7:0] rx_q[$];
    logic       in_pkt = 1'b0;
    logic       prev_busy = 1'b0;
    logic       prev_pv = 1'b0;
    logic [7:0] prev_data = 8'd0;
    logic       rand_busy = 1'b0;
    vec_t       vecs[7];

    router_pkt_framer_if bus();

    router_pkt_framer #(.GAP_CYCLES(GAP), .FIFO_DEPTH(64)) dut (
        .clock      (clock),
        .resetn     (resetn),
        .bus        (bus),
        .cmd_err    (cmd_err),
        .pkt_count  (pkt_count),
        .fifo_count (fifo_count)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    // Bus monitor: records every byte taken by the router (busy low), packet ends on the parity byte.
    initial begin
        forever begin
            @(negedge clock);
            if (!resetn) begin
                in_pkt = 1'b0;
                rx_q.delete();
                pv_run = 0;
                prev_busy = 1'b0;
            end else begin
                if (in_pkt && prev_busy) begin
                    chk("hold_valid", 32'(bus.pkt_valid), 32'(prev_pv));
                    chk("hold_data", 32'(bus.data_out), 32'(prev_data));
                end
                if (bus.pkt_valid) pv_run++;
                if (!bus.busy) begin
                    if (bus.pkt_valid) begin
                        rx_q.push_back(bus.data_out);
                        in_pkt = 1'b1;
                    end else if (in_pkt) begin
                        rx_q.push_back(bus.data_out);
                        in_pkt = 1'b0;
                        last_pv_run = pv_run;
                        pv_run = 0;
                        rx_pkts++;
                    end
                end
                prev_busy = bus.busy;
                prev_pv   = bus.pkt_valid;
                prev_data = bus.data_out;
            end
        end
    end

    initial begin
        forever begin
            @(posedge clock);
            #1;
            if (rand_busy) bus.busy = ($urandom_range(0, 3) == 0);
        end
    end

    task automatic push_byte(input logic [7:0] b);
        int n = 0;
        bus.pl_valid = 1'b1;
        bus.pl_data  = b;
        @(negedge clock);
        while (!bus.pl_ready && n < 100) begin
            @(negedge clock);
            n++;
        end
        chk("push_ready", 32'(bus.pl_ready), 32'd1);
        tick();
        bus.pl_valid = 1'b0;
        model_q.push_back(b);
    endtask

    task automatic push_n(input int n, input logic [7:0] first);
        for (int i = 0; i < n; i++) push_byte(i == 0 ? first : 8'($urandom));
    endtask

    task automatic send_cmd(input logic [1:0] a, input logic [5:0] l, input logic bp, output logic acc);
        bus.cmd_valid      = 1'b1;
        bus.cmd_addr       = a;
        bus.cmd_len        = l;
        bus.cmd_bad_parity = bp;
        acc = 1'b0;
        for (int i = 0; i < 200 && !acc; i++) begin
            @(negedge clock);
            acc = bus.cmd_ready;
        end
        tick();
        bus.cmd_valid      = 1'b0;
        bus.cmd_addr       = 2'($urandom);
        bus.cmd_len        = 6'($urandom);
        bus.cmd_bad_parity = 1'($urandom);
    endtask

    // Expected packet: header, the next len buffered bytes in order, then XOR of all of them (optionally inverted).
    task automatic expect_pkt(input logic [7:0] hdr, input int len, input logic bp, input string tag);
        int start = rx_pkts;
        int n = 0;
        logic [7:0] par, b, e;
        while (rx_pkts == start && n < 2000) begin
            tick();
            n++;
        end
        chk({tag, "_seen"}, 32'(rx_pkts - start), 32'd1);
        par = hdr;
        for (int i = 0; i < len + 2; i++) begin
            if (rx_q.size() > 0) b = rx_q.pop_front();
            else b = 8'hxx;
            if (i == 0) begin
                e = hdr;
            end else if (i <= len) begin
                if (model_q.size() > 0) e = model_q.pop_front();
                else e = 8'hxx;
                par = par ^ e;
            end else begin
                e = par ^ {8{bp}};
            end
            chk($sformatf("%s_byte%0d", tag, i), 32'(b), 32'(e));
        end
        chk({tag, "_extra"}, 32'(rx_q.size()), 32'd0);
        exp_pkts++;
        chk({tag, "_pkt_count"}, 32'(pkt_count), 32'(exp_pkts % 65536));
    endtask

    task automatic run_pkt(input logic [1:0] a, input logic [5:0] l, input logic bp,
                           input logic [7:0] hdr, input string tag);
        logic acc;
        send_cmd(a, l, bp, acc);
        chk({tag, "_accept"}, 32'(acc), 32'd1);
        @(negedge clock);
        chk({tag, "_hdr_valid"}, 32'(bus.pkt_valid), 32'd1);
        chk({tag, "_hdr"}, 32'(bus.data_out), 32'(hdr));
        expect_pkt(hdr, int'(l), bp, tag);
        idle(GAP + 1);
    endtask

    initial begin
        logic acc;
        int   fc;
        logic [1:0] ra;
        logic [5:0] rl;
        logic       rb;

        bus.cmd_valid = 1'b0; bus.cmd_addr = 2'd0; bus.cmd_len = 6'd0; bus.cmd_bad_parity = 1'b0;
        bus.pl_valid = 1'b0; bus.pl_data = 8'd0; bus.busy = 1'b0;
        idle(3);
        chk("rst_pkt_valid", 32'(bus.pkt_valid), 32'd0);
        chk("rst_data_out", 32'(bus.data_out), 32'd0);
        chk("rst_cmd_err", 32'(cmd_err), 32'd0);
        chk("rst_pkt_count", 32'(pkt_count), 32'd0);
        chk("rst_fifo_count", 32'(fifo_count), 32'd0);
        chk("rst_pl_ready", 32'(bus.pl_ready), 32'd1);
        resetn = 1'b1;
        idle(2);

        vecs[0] = '{2'd2, 6'd14, 1'b0, 8'h11, 1'b0, 8'h3A};
        vecs[1] = '{2'd1, 6'd63, 1'b0, 8'h9C, 1'b0, 8'hFD};
        vecs[2] = '{2'd0, 6'd1,  1'b1, 8'h55, 1'b0, 8'h04};
        vecs[3] = '{2'd3, 6'd4,  1'b0, 8'h00, 1'b1, 8'h00};
        vecs[4] = '{2'd2, 6'd0,  1'b0, 8'h00, 1'b1, 8'h00};
        vecs[5] = '{2'd3, 6'd0,  1'b1, 8'h00, 1'b1, 8'h00};
        vecs[6] = '{2'd0, 6'd32, 1'b1, 8'hC3, 1'b0, 8'h80};

        for (int v = 0; v < 7; v++) begin
            if (vecs[v].exp_err) begin
                push_n(3, 8'($urandom));
                fc = model_q.size();
                send_cmd(vecs[v].addr, vecs[v].len, vecs[v].bad, acc);
                chk($sformatf("vec%0d_accept", v), 32'(acc), 32'd1);
                @(negedge clock);
                chk($sformatf("vec%0d_err_pulse", v), 32'(cmd_err), 32'd1);
                chk($sformatf("vec%0d_err_idle", v), 32'(bus.pkt_valid), 32'd0);
                chk($sformatf("vec%0d_err_fifo", v), 32'(fifo_count), 32'(fc));
                @(negedge clock);
                chk($sformatf("vec%0d_err_once", v), 32'(cmd_err), 32'd0);
                chk($sformatf("vec%0d_err_bus", v), 32'(bus.pkt_valid), 32'd0);
                idle(1);
            end else begin
                push_n(int'(vecs[v].len), vecs[v].first);
                run_pkt(vecs[v].addr, vecs[v].len, vecs[v].bad, vecs[v].exp_hdr, $sformatf("vec%0d", v));
                chk($sformatf("vec%0d_pv_cycles", v), 32'(last_pv_run), 32'(int'(vecs[v].len) + 1));
            end
        end

        // Drain whatever the error vectors left buffered.
        if (model_q.size() > 0) begin
            rl = 6'(model_q.size());
            run_pkt(2'd0, rl, 1'b0, 8'(int'(rl) * 4), "drain");
        end

        // Three-cycle stall in the middle of the payload.
        push_n(14, 8'h7E);
        send_cmd(2'd2, 6'd14, 1'b0, acc);
        chk("stall_accept", 32'(acc), 32'd1);
        idle(4);
        bus.busy = 1'b1;
        idle(3);
        bus.busy = 1'b0;
        expect_pkt(8'h3A, 14, 1'b0, "stall");
        chk("stall_pv_cycles", 32'(last_pv_run), 32'd18);
        idle(GAP + 1);

        // Command waits until its payload is fully buffered.
        push_n(5, 8'h01);
        bus.cmd_valid = 1'b1; bus.cmd_addr = 2'd1; bus.cmd_len = 6'd8; bus.cmd_bad_parity = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            chk("short_not_ready", 32'(bus.cmd_ready), 32'd0);
            chk("short_bus_idle", 32'(bus.pkt_valid), 32'd0);
        end
        tick();
        push_n(3, 8'h08);
        @(negedge clock);
        chk("short_ready_after_8th", 32'(bus.cmd_ready), 32'd1);
        tick();
        bus.cmd_valid = 1'b0; bus.cmd_len = 6'd3; bus.cmd_addr = 2'd2;
        @(negedge clock);
        chk("short_hdr_valid", 32'(bus.pkt_valid), 32'd1);
        chk("short_hdr", 32'(bus.data_out), 32'h21);
        expect_pkt(8'h21, 8, 1'b0, "short");
        idle(GAP + 1);

        // Asynchronous reset in the middle of a payload.
        push_n(10, 8'h5A);
        send_cmd(2'd0, 6'd10, 1'b0, acc);
        chk("rst_pkt_accept", 32'(acc), 32'd1);
        idle(4);
        #2;
        resetn = 1'b0;
        #1;
        chk("midrst_pkt_valid", 32'(bus.pkt_valid), 32'd0);
        chk("midrst_data_out", 32'(bus.data_out), 32'd0);
        chk("midrst_fifo_count", 32'(fifo_count), 32'd0);
        chk("midrst_pkt_count", 32'(pkt_count), 32'd0);
        chk("midrst_cmd_err", 32'(cmd_err), 32'd0);
        model_q.delete();
        exp_pkts = 0;
        idle(2);
        resetn = 1'b1;
        idle(1);
        push_n(3, 8'hA5);
        run_pkt(2'd2, 6'd3, 1'b0, 8'h0E, "post_rst");

        // Randomized packets with random back-pressure.
        rand_busy = 1'b1;
        for (int k = 0; k < 25; k++) begin
            ra = 2'($urandom_range(0, 2));
            rl = 6'($urandom_range(1, 20));
            rb = 1'($urandom);
            push_n(int'(rl), 8'($urandom));
            run_pkt(ra, rl, rb, 8'(int'(rl) * 4 + int'(ra)), $sformatf("rnd%0d", k));
        end
        rand_busy = 1'b0;
        bus.busy = 1'b0;
        idle(2);

        // Fill the FIFO to capacity, try one extra push, then drain it.
        push_n(64, 8'hE1);
        @(negedge clock);
        chk("full_pl_ready", 32'(bus.pl_ready), 32'd0);
        chk("full_count", 32'(fifo_count), 32'd64);
        tick();
        bus.pl_valid = 1'b1; bus.pl_data = 8'hFF;
        tick();
        bus.pl_valid = 1'b0;
        @(negedge clock);
        chk("full_no_overflow", 32'(fifo_count), 32'd64);
        tick();
        run_pkt(2'd1, 6'd63, 1'b0, 8'hFD, "full63");
        run_pkt(2'd2, 6'd1, 1'b1, 8'h06, "full1");
        chk("empty_after_drain", 32'(fifo_count), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got time limit reached, want bench completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/router_pkt_framer.md
# router_pkt_framer

Upstream packet source for the 1x3 router. Buffers payload bytes from a producer, accepts per-packet commands, and serialises each packet onto the router input bus with correct framing: header, payload, then even-XOR parity. It obeys the router's `busy` back-pressure, guarantees no mid-packet bubbles, and can deliberately corrupt parity so downstream error paths can be exercised.

## Interface
- `GAP_CYCLES`, 2, idle cycles (`pkt_valid` low, no byte presented) forced after each parity byte; legal range 1..15.
- `FIFO_DEPTH`, 64, payload buffer depth in bytes; power of two, ≥ 63.
- `clock`  in  1  single clock; rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `cmd_valid`  in  1  command offered.
- `cmd_ready`  out  1  command accepted on an edge where `cmd_valid & cmd_ready`.
- `cmd_addr`  in  2  destination port 0..2; value 3 is illegal.
- `cmd_len`  in  6  payload length 1..63; value 0 is illegal.
- `cmd_bad_parity`  in  1  when set, the sent parity byte is inverted.
- `pl_valid`  in  1  payload byte offered.
- `pl_ready`  out  1  payload byte accepted on an edge where `pl_valid & pl_ready`.
- `pl_data`  in  8  payload byte.
- `busy`  in  1  router back-pressure.
- `pkt_valid`  out  1  high while a header or payload byte is presented.
- `data_out`  out  8  byte to the router's `data_in`.
- `cmd_err`  out  1  one-cycle pulse when an illegal command is consumed.
- `pkt_count`  out  16  number of packets completed; wraps modulo 2^16.
- `fifo_count`  out  7  payload bytes currently buffered.

## Operation
- Payload FIFO:
  - `pl_ready = !full`.
  - A simultaneous push and pop leaves the count unchanged.
  - Popping while empty cannot occur by construction.
- States: IDLE → HEADER → PAYLOAD → PARITY → GAP → IDLE.
- IDLE:
  - `cmd_ready = 1` only if the command is illegal, or `fifo_count ≥ cmd_len`.
  - An illegal command is consumed, `cmd_err` pulses, and the state stays IDLE. Nothing is sent and the FIFO is untouched.
  - A legal command latches `addr`, `len`, and `bad_parity`; the next state is HEADER.
- HEADER:
  - Drives `pkt_valid = 1` and `data_out = {len, addr}`.
  - Parity is initialised to the header value.
- PAYLOAD:
  - Pops one byte per transfer and XORs it into parity.
  - A down-counter starts at `len`; the last payload transfer moves the state to PARITY.
- PARITY:
  - Drives `pkt_valid = 0` and `data_out = parity ^ {8{bad_parity}}`.
  - On transfer, `pkt_count` increments and the state moves to GAP.
- GAP: holds for exactly `GAP_CYCLES` cycles with `pkt_valid = 0` and `data_out = 0`, then returns to IDLE.
- Transfer rule: a byte is transferred at a rising edge in HEADER, PAYLOAD or PARITY where `busy == 0`.
- While `busy == 1`, `pkt_valid` and `data_out` hold their values; no pop and no parity update occur.
- Because the whole payload is buffered before the command is accepted, `pkt_valid` never drops between header and parity.
- `cmd_len` and `cmd_addr` changing after acceptance have no effect.

## Timing
- Reset values: all outputs are 0, state is IDLE, the FIFO is empty, and parity is 0.
- Reset mid-packet: the current packet is aborted immediately and buffered payload is discarded.
- All outputs are registered, except `cmd_ready` and `pl_ready`, which are combinational from state and count.
- Latencies:
  - Command accepted at edge T → header appears on the bus from T+1.
  - With `busy` held low, a packet of length N occupies N+2 cycles (header, N payload, parity), followed by `GAP_CYCLES` idle cycles.
  - Back-to-back legal commands start at most `N + 2 + GAP_CYCLES + 1` cycles apart.
- A payload push at edge T is counted in `fifo_count` from T+1 and can satisfy a command evaluated in that cycle.
- `cmd_err` is high only in the cycle after the illegal command's acceptance edge.

## Structure
- Shared package `router_pkg` holds:
  - the state enumeration;
  - `ADDR_W = 2`, `LEN_W = 6`, `DATA_W = 8`;
  - `ADDR_INVALID = 2'b11`;
  - the header-pack function `{len, addr}`.
- One sub-module: `framer_fifo`, a synchronous `FIFO_DEPTH` × 8 FIFO with `count` output, flop-based storage, and pointers one bit wider than the address.

## Test plan
- Push 14 bytes, then issue command addr 2, len 14 with `busy` low → header 0x3A, then the 14 bytes in order, then a parity equal to XOR of all 15. `pkt_valid` is high for exactly 15 cycles; `pkt_count` = 1.
- Same packet with `busy` forced high for 3 cycles mid-payload → the current byte is held for 3 extra cycles, with no duplicates or drops and identical parity.
- Command len 8 with only 5 bytes buffered → `cmd_ready` stays 0 and the bus stays idle. Push 3 more → header 0x21 (for addr 1) the cycle after the 8th push is accepted.
- Command addr 3, len 4 → `cmd_err` pulses once, `fifo_count` is unchanged, and the bus stays idle. Repeat with len 0 → same response.
- Command with `cmd_bad_parity = 1`, addr 0, len 1, payload 0x55 → bus sequence 0x04, 0x55, then ~(0x04 ^ 0x55) = 0xAE.
- Assert `resetn` low during PAYLOAD → all outputs are 0 immediately and `fifo_count` = 0. A subsequent fresh packet is framed correctly.
